// File: rtl/register_bank_writeback_pkg.sv
// Shared constants for the EV22 register bank: data width, register address map and write-back FSM states.
package ev22_regs_pkg;

  localparam int DATA_W = 16;

  localparam logic [5:0] ADDR_PI0 = 6'd28;
  localparam logic [5:0] ADDR_PI1 = 6'd29;
  localparam logic [5:0] ADDR_PO0 = 6'd30;
  localparam logic [5:0] ADDR_PO1 = 6'd31;
  localparam logic [5:0] ADDR_R32 = 6'd32;
  localparam logic [5:0] ADDR_R33 = 6'd33;
  localparam logic [5:0] ADDR_WR  = 6'd34;

  typedef enum logic {
    IDLE   = 1'b0,
    NOTIFY = 1'b1
  } wb_state_e;

  // GPRs plus r30..r34 accept writes; the pi images and 35..63 do not.
  function automatic logic addr_writable(input logic [5:0] sel);
    return (sel < ADDR_PI0) || ((sel >= ADDR_PO0) && (sel <= ADDR_WR));
  endfunction

endpackage

// File: rtl/register_bank_writeback_if.sv
// ALU write-back channel into the register bank (valid/ready with error pulse).
interface register_bank_writeback_if #(
  parameter int DATA_W = ev22_regs_pkg::DATA_W
);
  logic              wb_valid;
  logic [5:0]        wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              wb_error;

  modport master (
    output wb_valid, wb_sel, wb_data,
    input  wb_ready, wb_error
  );

  modport slave (
    input  wb_valid, wb_sel, wb_data,
    output wb_ready, wb_error
  );
endinterface

// File: rtl/register_bank_writeback_input_port_sync.sv
// Multi-flop synchroniser bringing an asynchronous input port into the clk domain.
module input_port_sync #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_sync
);

  logic [DATA_W-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= port_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign port_sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/register_bank_writeback.sv
// EV22 architectural register bank: GPRs, port images/latches, specials and r34,
// with handshaked ALU write-back and an updateBlock pulse after each commit.
module register_bank_writeback #(
  parameter int DATA_W      = ev22_regs_pkg::DATA_W,
  parameter int N_GPR       = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  register_bank_writeback_if.slave wb,
  input  logic                    acc_we,
  input  logic [DATA_W-1:0]       acc_data,
  input  logic [DATA_W-1:0]       port_in0,
  input  logic [DATA_W-1:0]       port_in1,
  output logic [N_GPR*DATA_W-1:0] gpr_flat,
  output logic [DATA_W-1:0]       r32,
  output logic [DATA_W-1:0]       r33,
  output logic [DATA_W-1:0]       Working_Register,
  output logic [DATA_W-1:0]       pi0,
  output logic [DATA_W-1:0]       pi1,
  output logic [DATA_W-1:0]       port_out0,
  output logic [DATA_W-1:0]       port_out1,
  output logic                    updateBlock
);
  import ev22_regs_pkg::*;

  logic [DATA_W-1:0] gpr [N_GPR];
  wb_state_e         state;
  logic              hs;
  logic              writable;

  assign hs       = wb.wb_valid & wb.wb_ready;
  assign writable = addr_writable(wb.wb_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wb.wb_ready      <= 1'b0;
      wb.wb_error      <= 1'b0;
      updateBlock      <= 1'b0;
      r32              <= '0;
      r33              <= '0;
      Working_Register <= '0;
      port_out0        <= '0;
      port_out1        <= '0;
      for (int unsigned i = 0; i < N_GPR; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      // Unmapped/read-only writes still complete the handshake and visit NOTIFY.
      updateBlock <= hs | acc_we;
      wb.wb_error <= hs & ~writable;

      case (state)
        IDLE: begin
          if (hs) begin
            state       <= NOTIFY;
            wb.wb_ready <= 1'b0;
          end else begin
            wb.wb_ready <= 1'b1;
          end
        end
        NOTIFY: begin
          state       <= IDLE;
          wb.wb_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          wb.wb_ready <= 1'b0;
        end
      endcase

      if (acc_we) begin
        Working_Register <= acc_data;
      end

      // Placed after the accumulator update so a same-cycle write-back to r34 wins.
      if (hs) begin
        for (int unsigned i = 0; i < N_GPR; i++) begin
          if (wb.wb_sel == 6'(i)) begin
            gpr[i] <= wb.wb_data;
          end
        end
        case (wb.wb_sel)
          ADDR_PO0: port_out0        <= wb.wb_data;
          ADDR_PO1: port_out1        <= wb.wb_data;
          ADDR_R32: r32              <= wb.wb_data;
          ADDR_R33: r33              <= wb.wb_data;
          ADDR_WR:  Working_Register <= wb.wb_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    gpr_flat = '0;
    for (int unsigned i = 0; i < N_GPR; i++) begin
      gpr_flat[i*DATA_W +: DATA_W] = gpr[i];
    end
  end

  input_port_sync #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_pi0 (
    .clk       (clk),
    .reset     (reset),
    .port_in   (port_in0),
    .port_sync (pi0)
  );

  input_port_sync #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_pi1 (
    .clk       (clk),
    .reset     (reset),
    .port_in   (port_in1),
    .port_sync (pi1)
  );

endmodule

// File: tb/tb_register_bank_writeback.sv
// Scoreboard bench for register_bank_writeback: every updateBlock pulse is matched
// against the expectation queued when the write or accumulator update was driven.
module tb_register_bank_writeback;

  localparam int DW = 16;
  localparam int NG = 28;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  register_bank_writeback_if #(.DATA_W(DW)) wb();

  logic             acc_we;
  logic [DW-1:0]    acc_data;
  logic [DW-1:0]    port_in0, port_in1;
  logic [NG*DW-1:0] gpr_flat;
  logic [DW-1:0]    r32, r33, Working_Register, pi0, pi1, port_out0, port_out1;
  logic             updateBlock;

  register_bank_writeback #(
    .DATA_W      (DW),
    .N_GPR       (NG),
    .SYNC_STAGES (SS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb               (wb),
    .acc_we           (acc_we),
    .acc_data         (acc_data),
    .port_in0         (port_in0),
    .port_in1         (port_in1),
    .gpr_flat         (gpr_flat),
    .r32              (r32),
    .r33              (r33),
    .Working_Register (Working_Register),
    .pi0              (pi0),
    .pi1              (pi1),
    .port_out0        (port_out0),
    .port_out1        (port_out1),
    .updateBlock      (updateBlock)
  );

  typedef struct {
    string            tag;
    logic [5:0]       sel;
    logic             chk_val;
    logic [DW-1:0]    val;
    logic             err;
    logic             is_wb;
    logic [NG*DW-1:0] flat;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] model [35];
  int            errors = 0;
  int            checks = 0;

  task automatic check_eq(input string tag, input logic [NG*DW-1:0] act, input logic [NG*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NG*DW-1:0] model_flat();
    logic [NG*DW-1:0] r;
    for (int i = 0; i < NG; i++) r[i*DW +: DW] = model[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] read_reg(input logic [5:0] sel);
    case (sel)
      6'd28:   return pi0;
      6'd29:   return pi1;
      6'd30:   return port_out0;
      6'd31:   return port_out1;
      6'd32:   return r32;
      6'd33:   return r33;
      6'd34:   return Working_Register;
      default: return gpr_flat[sel*DW +: DW];
    endcase
  endfunction

  function automatic logic tb_writable(input logic [5:0] sel);
    return (sel <= 6'd27) || ((sel >= 6'd30) && (sel <= 6'd34));
  endfunction

  always @(negedge clk) begin
    if (updateBlock === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_ub", updateBlock, 0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_val) check_eq({mon_e.tag, "_val"}, read_reg(mon_e.sel), mon_e.val);
        check_eq({mon_e.tag, "_err"}, wb.wb_error, mon_e.err);
        check_eq({mon_e.tag, "_flat"}, gpr_flat, mon_e.flat);
        if (mon_e.is_wb) check_eq({mon_e.tag, "_rdy_low"}, wb.wb_ready, 0);
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (wb.wb_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq({tag, "_ready_timeout"}, wb.wb_ready, 1);
  endtask

  task automatic push_exp(input string tag, input logic [5:0] sel, input logic err, input logic is_wb);
    exp_t e;
    e.tag     = tag;
    e.sel     = sel;
    e.chk_val = (sel <= 6'd34);
    e.val     = (sel <= 6'd34) ? model[sel] : '0;
    e.err     = err;
    e.is_wb   = is_wb;
    e.flat    = model_flat();
    sb.push_back(e);
  endtask

  task automatic wb_write(input string tag, input logic [5:0] sel, input logic [DW-1:0] data,
                          input logic acc, input logic [DW-1:0] adata);
    logic w;
    wait_ready(tag);
    w = tb_writable(sel);
    if (acc) model[34] = adata;
    if (w) model[sel] = data;
    push_exp(tag, sel, !w, 1'b1);
    wb.wb_valid = 1'b1;
    wb.wb_sel   = sel;
    wb.wb_data  = data;
    acc_we      = acc;
    acc_data    = adata;
    @(posedge clk);
    #1;
    wb.wb_valid = 1'b0;
    acc_we      = 1'b0;
    @(negedge clk);
    #1;
    check_eq({tag, "_drain"}, sb.size(), 0);
    @(negedge clk);
    check_eq({tag, "_rdy_back"}, wb.wb_ready, 1);
    check_eq({tag, "_ub_single"}, updateBlock, 0);
    check_eq({tag, "_err_clear"}, wb.wb_error, 0);
  endtask

  typedef struct { logic [5:0] sel; logic [DW-1:0] data; } wr_t;
  wr_t tbl[$];

  initial begin
    wb.wb_valid = 1'b0;
    wb.wb_sel   = '0;
    wb.wb_data  = '0;
    acc_we      = 1'b0;
    acc_data    = '0;
    port_in0    = '0;
    port_in1    = '0;
    for (int i = 0; i < 35; i++) model[i] = '0;

    // reset for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ready", wb.wb_ready, 0);
      check_eq("rst_ub", updateBlock, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", wb.wb_ready, 1);
    check_eq("post_rst_ub", updateBlock, 0);
    check_eq("post_rst_err", wb.wb_error, 0);
    check_eq("post_rst_gpr", gpr_flat, 0);
    check_eq("post_rst_wr", Working_Register, 0);
    check_eq("post_rst_r32", r32, 0);
    check_eq("post_rst_r33", r33, 0);
    check_eq("post_rst_po0", port_out0, 0);
    check_eq("post_rst_po1", port_out1, 0);
    check_eq("post_rst_pi0", pi0, 0);
    check_eq("post_rst_pi1", pi1, 0);

    tbl = '{'{6'd5, 16'hBEEF}, '{6'd0, 16'h0001}, '{6'd27, 16'hFFFF}, '{6'd31, 16'h5A5A},
            '{6'd32, 16'h1357}, '{6'd33, 16'h2468}, '{6'd34, 16'h0F0F}, '{6'd28, 16'h1234},
            '{6'd40, 16'hDEAD}, '{6'd63, 16'hFFFF}, '{6'd29, 16'hABCD}, '{6'd35, 16'h7777}};
    foreach (tbl[i]) begin
      wb_write($sformatf("wr_sel%0d", tbl[i].sel), tbl[i].sel, tbl[i].data, 1'b0, '0);
    end
    check_eq("beef_slice", gpr_flat[95:80], 16'hBEEF);

    for (int i = 0; i < 8; i++) begin
      logic [5:0]    s;
      logic [DW-1:0] d;
      s = 6'($urandom_range(34, 0));
      d = DW'($urandom());
      wb_write($sformatf("rnd%0d_sel%0d", i, s), s, d, 1'b0, '0);
    end

    // write-back and accumulator both target r34 in the same cycle
    wb_write("combo", 6'd34, 16'h00AA, 1'b1, 16'h0055);
    check_eq("combo_wr", Working_Register, 16'h00AA);

    // back-to-back accumulator updates keep updateBlock high
    @(negedge clk);
    acc_we   = 1'b1;
    acc_data = 16'h1111;
    model[34] = 16'h1111;
    push_exp("acc0", 6'd34, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    acc_data  = 16'h2222;
    model[34] = 16'h2222;
    push_exp("acc1", 6'd34, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    acc_we = 1'b0;
    @(negedge clk);
    #1;
    check_eq("acc_drain", sb.size(), 0);
    @(negedge clk);
    check_eq("acc_ub_end", updateBlock, 0);

    // input port synchroniser latency
    @(posedge clk);
    #1;
    port_in1 = 16'h0F0F;
    @(negedge clk);
    @(negedge clk);
    check_eq("pi1_early", pi1, 0);
    check_eq("pi1_early_ub", updateBlock, 0);
    @(negedge clk);
    check_eq("pi1_sync", pi1, 16'h0F0F);
    check_eq("pi1_sync_ub", updateBlock, 0);
    check_eq("pi0_still", pi0, 0);

    // reset arrives during the NOTIFY cycle of a port_out0 write
    wait_ready("rstmid");
    model[30] = 16'h8001;
    push_exp("rstmid", 6'd30, 1'b0, 1'b1);
    wb.wb_valid = 1'b1;
    wb.wb_sel   = 6'd30;
    wb.wb_data  = 16'h8001;
    @(posedge clk);
    #1;
    wb.wb_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid_drain", sb.size(), 0);
    @(negedge clk);
    check_eq("rstmid_ub", updateBlock, 0);
    check_eq("rstmid_po0", port_out0, 0);
    check_eq("rstmid_ready", wb.wb_ready, 0);
    check_eq("rstmid_pi1", pi1, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rstmid_ready_back", wb.wb_ready, 1);
    check_eq("rstmid_gpr", gpr_flat, 0);
    check_eq("rstmid_wr", Working_Register, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
